// File: rtl/duty.sv
// Balance-loop PID mixer: weights pitch error, integral and derivative, then
// registers a saturated duty magnitude plus a reverse flag for the PWM stage.
module duty #(
  parameter int P_COEFF  = 9,
  parameter int D_COEFF  = 20,
  parameter int DUTY_MAX = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ptch_D_diff_sat,
  input  logic [9:0]  ptch_err_sat,
  input  logic [9:0]  ptch_err_I,
  output logic [10:0] mtr_duty,
  output logic        rev
);

  logic signed [14:0] err_ext, p_gain, p_term, i_term, d_term;
  logic signed [12:0] d_ext, d_gain, d_prod;
  logic signed [15:0] pid_sum;
  logic        [15:0] mag;
  logic               neg;
  logic        [10:0] duty_nxt;

  // Operands are widened to the product width first, so every multiply is signed-by-positive.
  always_comb begin
    err_ext = {{5{ptch_err_sat[9]}}, ptch_err_sat};
    p_gain  = 15'(P_COEFF);
    p_term  = err_ext * p_gain;

    i_term  = {{5{ptch_err_I[9]}}, ptch_err_I};

    d_ext   = {{6{ptch_D_diff_sat[6]}}, ptch_D_diff_sat};
    d_gain  = 13'(D_COEFF);
    d_prod  = d_ext * d_gain;
    d_term  = {{2{d_prod[12]}}, d_prod};

    pid_sum = {p_term[14], p_term} + {i_term[14], i_term} + {d_term[14], d_term};

    neg     = pid_sum[15];
    mag     = neg ? 16'(-pid_sum) : 16'(pid_sum);

    duty_nxt = (mag > 16'(DUTY_MAX)) ? 11'(DUTY_MAX) : mag[10:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtr_duty <= '0;
      rev      <= 1'b0;
    end else begin
      mtr_duty <= duty_nxt;
      rev      <= neg;
    end
  end

endmodule

// File: tb/tb_duty.sv
// Directed bench for duty: hand-computed vectors checked one cycle after each edge.
module tb_duty;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  ptch_D_diff_sat = '0;
  logic [9:0]  ptch_err_sat = '0;
  logic [9:0]  ptch_err_I = '0;
  logic [10:0] mtr_duty;
  logic        rev;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  duty #(.P_COEFF(9), .D_COEFF(20), .DUTY_MAX(2047)) dut (
    .clk             (clk),
    .rst             (rst),
    .ptch_D_diff_sat (ptch_D_diff_sat),
    .ptch_err_sat    (ptch_err_sat),
    .ptch_err_I      (ptch_err_I),
    .mtr_duty        (mtr_duty),
    .rev             (rev)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] obs_duty, input logic obs_rev,
                       input logic [10:0] exp_duty, input logic exp_rev);
    n_checks++;
    assert (obs_duty === exp_duty && obs_rev === exp_rev) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed duty=%0d rev=%0b expected duty=%0d rev=%0b",
             tag, obs_duty, obs_rev, exp_duty, exp_rev);
    end
  endtask

  task automatic step(input string tag, input logic r, input int d, input int e, input int i,
                      input int exp_duty, input logic exp_rev);
    rst             = r;
    ptch_D_diff_sat = 7'(d);
    ptch_err_sat    = 10'(e);
    ptch_err_I      = 10'(i);
    @(posedge clk);
    #1;
    check(tag, mtr_duty, rev, 11'(exp_duty), exp_rev);
  endtask

  initial begin
    // reset with nonzero inputs
    step("reset_1", 1'b1, 1, 4, -4, 0, 1'b0);
    step("reset_2", 1'b1, -8, -16, 6, 0, 1'b0);
    step("release_pos_mix", 1'b0, 1, 4, -4, 52, 1'b0);
    step("neg_mix", 1'b0, -8, -16, 6, 298, 1'b1);

    // latency: new inputs visible only after the next edge
    ptch_D_diff_sat = 7'(0);
    ptch_err_sat    = 10'(100);
    ptch_err_I      = 10'(0);
    #2;
    check("latency_hold", mtr_duty, rev, 11'd298, 1'b1);
    @(posedge clk);
    #1;
    check("latency_update", mtr_duty, rev, 11'd900, 1'b0);

    step("pos_sat", 1'b0, 63, 511, 511, 2047, 1'b0);
    step("neg_sat", 1'b0, -64, -512, -512, 2047, 1'b1);
    step("zero", 1'b0, 0, 0, 0, 0, 1'b0);
    step("cancel", 1'b0, 1, 0, -20, 0, 1'b0);

    // individual full-scale negative terms keep their sign
    step("p_only_neg", 1'b0, 0, -100, 0, 900, 1'b1);
    step("d_only_fullneg", 1'b0, -64, 0, 0, 1280, 1'b1);
    step("i_only_fullneg", 1'b0, 0, 0, -512, 512, 1'b1);
    step("p_only_fullneg", 1'b0, 0, -512, 0, 2047, 1'b1);
    step("d_only_pos", 1'b0, 63, 0, 0, 1260, 1'b0);

    // saturation threshold: 227*9 = 2043
    step("sat_below", 1'b0, 0, 227, 3, 2046, 1'b0);
    step("sat_equal", 1'b0, 0, 227, 4, 2047, 1'b0);
    step("sat_above", 1'b0, 0, 227, 5, 2047, 1'b0);
    step("sat_neg_below", 1'b0, 0, -227, -3, 2046, 1'b1);
    step("minus_one", 1'b0, 0, 0, -1, 1, 1'b1);

    // reset mid-stream clears on that edge, then tracking resumes
    step("midreset", 1'b1, -8, -16, 6, 0, 1'b0);
    step("after_midreset", 1'b0, -8, -16, 6, 298, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
